cv32e40p_tmr_recovery_ctrl: RTL and testbench

Recovery controller for the triple-modular-redundant instruction aligner. Watches the per-replica mismatch flags produced by the aligner's majority voters, stalls instruction fetch, and resynchronises a faulty replica from the voted state. It tracks per-replica error statistics, retires replicas that keep failing, and raises a sticky fatal flag when no majority exists. It sits between the fault-tolerant aligner and the IF-stage stall logic.

---
 rtl/cv32e40p_tmr_recovery_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cv32e40p_tmr_recovery_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tmr_recovery_ctrl.sv
// Recovery controller for the TMR instruction aligner: stalls fetch, resyncs a faulty replica,
// tracks error statistics. Optional replica retirement via CV32E40P_TMR_REPLICA_RETIRE_EN.
module cv32e40p_tmr_recovery_ctrl #(
   parameter int unsigned ERR_CNT_W     = 8,
   parameter int unsigned PERSIST_THR   = 3,
   parameter int unsigned RESYNC_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   check_en_i,
   input  logic [2:0]             mismatch_i,
   input  logic                   clear_cnt_i,
   output logic                   stall_o,
   output logic [2:0]             resync_o,
   output logic [2:0]             disable_o,
   output logic                   err_detected_o,
   output logic                   err_corrected_o,
   output logic                   fatal_o,
   output logic [3*ERR_CNT_W-1:0] err_cnt_o
);

   localparam int unsigned PW = $clog2(PERSIST_THR + 1);
   localparam int unsigned RW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
   localparam logic [PW-1:0] PERSIST_LIM = PW'(PERSIST_THR);
   localparam logic [RW-1:0] RESYNC_LOAD = RW'(RESYNC_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STALL,
      S_RESYNC,
      S_CHECK,
      S_FATAL
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             f_q, f_d;
   logic [RW-1:0]          rs_cnt_q, rs_cnt_d;
   logic [PW-1:0]          persist_q [3];
   logic [PW-1:0]          persist_d [3];
   logic [PW-1:0]          persist_inc;
   logic                   det_q, det_d;
   logic                   corr_q, corr_d;
   logic                   inc_en;
   logic [ERR_CNT_W-1:0]   err_cnt_q [3];
   logic [2:0]             disable_q;
   logic [2:0]             m;
   logic [2:0]             f_mask;
   logic [1:0]             m_idx;
   logic                   correctable;

   function automatic logic [1:0] onehot_idx(input logic [2:0] v);
      if (v[2])      return 2'd2;
      else if (v[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   assign m           = mismatch_i & ~disable_q;
   assign m_idx       = onehot_idx(m);
   assign f_mask      = 3'b001 << f_q;
   // A single disagreeing replica is only fixable while all three still vote.
   assign correctable = $onehot(m) && (disable_q == 3'b000);
   assign persist_inc = persist_q[f_q] + 1'b1;

`ifdef CV32E40P_TMR_REPLICA_RETIRE_EN
   logic [2:0] disable_d;

   always_ff @(posedge clk) begin
      if (rst) disable_q <= '0;
      else     disable_q <= disable_d;
   end
`else
   assign disable_q = '0;
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      f_d       = f_q;
      rs_cnt_d  = rs_cnt_q;
      persist_d = persist_q;
      det_d     = 1'b0;
      corr_d    = 1'b0;
      inc_en    = 1'b0;
`ifdef CV32E40P_TMR_REPLICA_RETIRE_EN
      disable_d = disable_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (check_en_i && (m != 3'b000)) begin
               det_d = 1'b1;
               if (correctable) begin
                  f_d     = m_idx;
                  inc_en  = 1'b1;
                  state_d = S_STALL;
               end else begin
                  state_d = S_FATAL;
               end
            end
         end
         S_STALL: begin
            rs_cnt_d = RESYNC_LOAD;
            state_d  = S_RESYNC;
         end
         S_RESYNC: begin
            if (rs_cnt_q == '0) state_d = S_CHECK;
            else                rs_cnt_d = rs_cnt_q - 1'b1;
         end
         S_CHECK: begin
            if (m == 3'b000) begin
               corr_d         = 1'b1;
               persist_d[f_q] = '0;
               state_d        = S_IDLE;
            end else if (m == f_mask) begin
               if (persist_inc >= PERSIST_LIM) begin
`ifdef CV32E40P_TMR_REPLICA_RETIRE_EN
                  disable_d[f_q] = 1'b1;
                  persist_d[f_q] = '0;
                  corr_d         = 1'b1;
                  state_d        = S_IDLE;
`else
                  persist_d[f_q] = persist_inc;
                  state_d        = S_FATAL;
`endif
               end else begin
                  persist_d[f_q] = persist_inc;
                  rs_cnt_d       = RESYNC_LOAD;
                  state_d        = S_RESYNC;
               end
            end else begin
               state_d = S_FATAL;
            end
         end
         S_FATAL: state_d = S_FATAL;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q  <= S_IDLE;
         f_q      <= '0;
         rs_cnt_q <= '0;
         det_q    <= 1'b0;
         corr_q   <= 1'b0;
         // NOTE: these arrays are three small registers, not a RAM, so resetting them is cheap and required.
         for (int i = 0; i < 3; i++) persist_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         f_q       <= f_d;
         rs_cnt_q  <= rs_cnt_d;
         det_q     <= det_d;
         corr_q    <= corr_d;
         persist_q <= persist_d;
      end
   end

   // Clear takes priority over a same-cycle increment; saturate at all ones.
   always_ff @(posedge clk) begin
      if (rst || clear_cnt_i) begin
         for (int i = 0; i < 3; i++) err_cnt_q[i] <= '0;
      end else if (inc_en && (err_cnt_q[m_idx] != '1)) begin
         err_cnt_q[m_idx] <= err_cnt_q[m_idx] + 1'b1;
      end
   end

   always_comb begin
      err_cnt_o = '0;
      for (int i = 0; i < 3; i++) err_cnt_o[i*ERR_CNT_W +: ERR_CNT_W] = err_cnt_q[i];
   end

   assign stall_o         = (state_q != S_IDLE);
   assign resync_o        = (state_q == S_RESYNC) ? f_mask : 3'b000;
   assign fatal_o         = (state_q == S_FATAL);
   assign disable_o       = disable_q;
   assign err_detected_o  = det_q;
   assign err_corrected_o = corr_q;

endmodule

// File: tb/tb_cv32e40p_tmr_recovery_ctrl.sv
// Scoreboard bench for cv32e40p_tmr_recovery_ctrl: an episode-level timeline model pushes the
// expected outputs of every cycle; a monitor pops and compares on the falling edge.
module tb_cv32e40p_tmr_recovery_ctrl;

   localparam int CW    = 8;
   localparam int THR   = 3;
   localparam int RCYC  = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            check_en_i = 1'b0;
   logic [2:0]      mismatch_i = 3'b000;
   logic            clear_cnt_i = 1'b0;
   logic            stall_o;
   logic [2:0]      resync_o;
   logic [2:0]      disable_o;
   logic            err_detected_o;
   logic            err_corrected_o;
   logic            fatal_o;
   logic [3*CW-1:0] err_cnt_o;

   cv32e40p_tmr_recovery_ctrl #(
      .ERR_CNT_W     (CW),
      .PERSIST_THR   (THR),
      .RESYNC_CYCLES (RCYC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .check_en_i      (check_en_i),
      .mismatch_i      (mismatch_i),
      .clear_cnt_i     (clear_cnt_i),
      .stall_o         (stall_o),
      .resync_o        (resync_o),
      .disable_o       (disable_o),
      .err_detected_o  (err_detected_o),
      .err_corrected_o (err_corrected_o),
      .fatal_o         (fatal_o),
      .err_cnt_o       (err_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            stall;
      logic [2:0]      resync;
      logic [2:0]      dis;
      logic            det;
      logic            corr;
      logic            fatal;
      logic [3*CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Reference model state, kept as plain integers and flags.
   int         m_cnt [3];
   int         m_persist [3];
   logic [2:0] m_dis;
   bit         m_fatal;
   bit         pend_det;
   bit         pend_corr;

   function automatic logic [3*CW-1:0] pack_cnt();
      logic [3*CW-1:0] v;
      for (int i = 0; i < 3; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
      return v;
   endfunction

   function automatic int idx_of(input logic [2:0] v);
      for (int i = 0; i < 3; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [2:0] oh(input int i);
      logic [2:0] v;
      v = 3'b000;
      v[i] = 1'b1;
      return v;
   endfunction

   // One clock cycle: record what the DUT must show this cycle, drive inputs, advance model counters.
   task automatic cycle(input bit en, input logic [2:0] mis, input bit clr,
                        input bit stall, input logic [2:0] rs, input int inc_idx);
      exp_t e;
      e.stall  = stall;
      e.resync = rs;
      e.dis    = m_dis;
      e.det    = pend_det;
      e.corr   = pend_corr;
      e.fatal  = m_fatal;
      e.cnt    = pack_cnt();
      pend_det  = 1'b0;
      pend_corr = 1'b0;
      exp_q.push_back(e);
      check_en_i  = en;
      mismatch_i  = mis;
      clear_cnt_i = clr;
      @(posedge clk);
      #1;
      if (clr) begin
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end else if (inc_idx >= 0 && m_cnt[inc_idx] < CMAX) begin
         m_cnt[inc_idx]++;
      end
   endtask

   task automatic do_reset();
      exp_t z;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_persist[i] = 0;
      end
      m_dis = 3'b000;
      m_fatal = 1'b0;
      pend_det = 1'b0;
      pend_corr = 1'b0;
      z = '0;
      exp_q.push_back(z);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // mode 0 random, 1 clean, 2 same replica keeps failing, 3 everything disagrees
   function automatic logic [2:0] pick_check(input int mode, input int f);
      int r;
      case (mode)
         1: return 3'b000;
         2: return oh(f);
         3: return 3'b111;
         default: begin
            r = $urandom_range(0, 9);
            if (r < 6)      return 3'($urandom) & m_dis;
            else if (r < 9) return oh(f);
            else            return 3'($urandom);
         end
      endcase
   endfunction

   // One IDLE-or-FATAL cycle; a correctable detection expands into its whole episode timeline.
   task automatic step(input bit en, input logic [2:0] mis, input bit clr, input int mode);
      logic [2:0] m, chk, cm;
      int f;
      if (m_fatal) begin
         cycle(en, mis, clr, 1'b1, 3'b000, -1);
         return;
      end
      m = mis & ~m_dis;
      if (!en || m == 3'b000) begin
         cycle(en, mis, clr, 1'b0, 3'b000, -1);
         return;
      end
      if ($onehot(m) && m_dis == 3'b000) begin
         f = idx_of(m);
         cycle(en, mis, clr, 1'b0, 3'b000, f);
         pend_det = 1'b1;
         cycle(1'($urandom), 3'($urandom), 1'b0, 1'b1, 3'b000, -1);
         while (1) begin
            for (int k = 0; k < RCYC; k++)
               cycle(1'($urandom), 3'($urandom), 1'b0, 1'b1, oh(f), -1);
            chk = pick_check(mode, f);
            cycle(1'($urandom), chk, 1'b0, 1'b1, 3'b000, -1);
            cm = chk & ~m_dis;
            if (cm == 3'b000) begin
               pend_corr = 1'b1;
               m_persist[f] = 0;
               return;
            end else if (cm == oh(f)) begin
               m_persist[f]++;
               if (m_persist[f] >= THR) begin
`ifdef CV32E40P_TMR_REPLICA_RETIRE_EN
                  m_dis[f] = 1'b1;
                  m_persist[f] = 0;
                  pend_corr = 1'b1;
`else
                  m_fatal = 1'b1;
`endif
                  return;
               end
            end else begin
               m_fatal = 1'b1;
               return;
            end
         end
      end
      cycle(en, mis, clr, 1'b0, 3'b000, -1);
      pend_det = 1'b1;
      m_fatal = 1'b1;
   endtask

   function automatic logic [2:0] rand_mis();
      int r;
      r = $urandom_range(0, 19);
      if (r < 10)      return 3'b000;
      else if (r < 17) return oh($urandom_range(0, 2));
      else             return 3'($urandom);
   endfunction

   // Monitor: every cycle with a pending expectation is compared on the falling edge.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.stall  = stall_o;
            a.resync = resync_o;
            a.dis    = disable_o;
            a.det    = err_detected_o;
            a.corr   = err_corrected_o;
            a.fatal  = fatal_o;
            a.cnt    = err_cnt_o;
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL outputs @cycle %0d: got stall=%b rs=%b dis=%b det=%b corr=%b fatal=%b cnt=%h, expected stall=%b rs=%b dis=%b det=%b corr=%b fatal=%b cnt=%h",
                        cyc, a.stall, a.resync, a.dis, a.det, a.corr, a.fatal, a.cnt,
                        e.stall, e.resync, e.dis, e.det, e.corr, e.fatal, e.cnt);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();

      // Clean traffic: no stall, no pulses, counters stay zero.
      for (int i = 0; i < 20; i++) step(1'b1, 3'b000, 1'b0, 1);

      // Single correctable error on replica 1.
      step(1'b1, 3'b010, 1'b0, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b0, 1);

      // Replica 0 keeps failing through every check.
      step(1'b1, 3'b001, 1'b0, 2);
      for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b0, 1);
      step(1'b1, 3'b010, 1'b0, 1);
      for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 1'b0, 1);
      do_reset();

      // Two replicas disagree: straight to fatal until reset.
      step(1'b1, 3'b110, 1'b0, 1);
      for (int i = 0; i < 6; i++) step(1'b1, rand_mis(), 1'b0, 1);
      do_reset();

      // Reset in the middle of a resync.
      cycle(1'b1, 3'b100, 1'b0, 1'b0, 3'b000, 2);
      pend_det = 1'b1;
      cycle(1'b0, 3'b000, 1'b0, 1'b1, 3'b000, -1);
      cycle(1'b0, 3'b000, 1'b0, 1'b1, 3'b100, -1);
      do_reset();

      // Saturate replica 2's counter, then clear on the same cycle as an increment.
      for (int i = 0; i < CMAX + 2; i++) step(1'b1, 3'b100, 1'b0, 1);
      step(1'b1, 3'b000, 1'b0, 1);
      step(1'b1, 3'b100, 1'b1, 1);
      for (int i = 0; i < 2; i++) step(1'b1, 3'b000, 1'b0, 1);

      // Randomized traffic with occasional counter clears and resets out of fatal.
      for (int n = 0; n < 400; n++) begin
         if (m_fatal && $urandom_range(0, 3) == 0) do_reset();
         else step(($urandom_range(0, 3) != 0), rand_mis(), ($urandom_range(0, 29) == 0), 0);
      end
      step(1'b0, 3'b000, 1'b0, 1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
